// File: rtl/fifo8x9_pkg.sv
// rtl/fifo8x9_pkg.sv - shared constants and state encoding for the 8x9 FIFO controller
package fifo8x9_pkg;

    localparam int DEPTH  = 8;
    localparam int DW     = 9;
    localparam int CNT_W  = 4;
    localparam int AF_LVL = 6;
    localparam int AE_LVL = 1;

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with a last-grant register
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    // index of the requester granted most recently; 1 after reset so requester 0 wins the first tie
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // grant is only issued to an active requester, so every grant is a handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo8x9_ctrl.sv
// rtl/fifo8x9_ctrl.sv - write arbiter and sequencer for the 8x9 FIFO storage block
// FIFO8X9_CTRL_ALMOST_EN adds registered almost_full / almost_empty outputs.
module fifo8x9_ctrl
    import fifo8x9_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_valid,
    input  logic [DW-1:0]    p0_data,
    output logic             p0_ready,
    input  logic             p1_valid,
    input  logic [DW-1:0]    p1_data,
    output logic             p1_ready,
    input  logic             pop_req,
    output logic             pop_ready,
    output logic             rd_valid,
    output logic [DW-1:0]    rd_data,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             fifo_wren,
    output logic             fifo_wrinc,
    output logic             fifo_rden,
    output logic             fifo_rdinc,
    output logic             fifo_wrptrclr,
    output logic             fifo_rdptrclr,
    output logic [DW-1:0]    fifo_datain,
    input  logic [DW-1:0]    fifo_dataout
`ifdef FIFO8X9_CTRL_ALMOST_EN
    ,
    output logic             almost_full,
    output logic             almost_empty
`endif
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [1:0]       grant;
    logic             push_en;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_next;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign push_en = (state == RUN) && !full && !flush;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({p1_valid, p0_valid}),
        .en    (push_en),
        .grant (grant)
    );

    assign p0_ready  = grant[0];
    assign p1_ready  = grant[1];
    assign push      = |grant;
    assign pop_ready = (state == RUN) && !empty && !flush;
    assign pop       = pop_req && pop_ready;

    assign fifo_wren     = push;
    assign fifo_wrinc    = push;
    assign fifo_rden     = pop;
    assign fifo_rdinc    = pop;
    assign fifo_wrptrclr = (state != RUN);
    assign fifo_rdptrclr = (state != RUN);
    assign fifo_datain   = grant[1] ? p1_data : p0_data;
    assign rd_data       = fifo_dataout;

    always_comb begin
        state_next = state;
        case (state)
            INIT:    state_next = RUN;
            RUN:     state_next = flush ? FLUSH : RUN;
            FLUSH:   state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        count_next = count;
        if (state == FLUSH) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // rd_valid follows any accepted pop, including one taken just before a flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            rd_valid <= pop;
        end
    end

`ifdef FIFO8X9_CTRL_ALMOST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_next >= CNT_W'(AF_LVL));
            almost_empty <= (count_next <= CNT_W'(AE_LVL));
        end
    end
`endif

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// tb/tb_fifo8x9_ctrl.sv - self-checking bench for fifo8x9_ctrl with a behavioural storage block
module tb_fifo8x9_ctrl;
    import fifo8x9_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             p0_valid = 1'b0, p1_valid = 1'b0, pop_req = 1'b0, flush = 1'b0;
    logic [DW-1:0]    p0_data = '0, p1_data = '0;
    logic             p0_ready, p1_ready, pop_ready, rd_valid, full, empty;
    logic [DW-1:0]    rd_data, fifo_datain;
    logic [DW-1:0]    fifo_dataout = '0;
    logic [CNT_W-1:0] count;
    logic             fifo_wren, fifo_wrinc, fifo_rden, fifo_rdinc, fifo_wrptrclr, fifo_rdptrclr;
`ifdef FIFO8X9_CTRL_ALMOST_EN
    logic             almost_full, almost_empty;
`endif

    fifo8x9_ctrl dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
        .pop_req(pop_req), .pop_ready(pop_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .flush(flush), .count(count), .full(full), .empty(empty),
        .fifo_wren(fifo_wren), .fifo_wrinc(fifo_wrinc),
        .fifo_rden(fifo_rden), .fifo_rdinc(fifo_rdinc),
        .fifo_wrptrclr(fifo_wrptrclr), .fifo_rdptrclr(fifo_rdptrclr),
        .fifo_datain(fifo_datain), .fifo_dataout(fifo_dataout)
`ifdef FIFO8X9_CTRL_ALMOST_EN
        , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
    );

    always #5 clk = ~clk;

    // storage block: free-running 8-bit pointers, no reset, registered read
    logic [DW-1:0] mem [8];
    logic [7:0]    wp = 8'd0, rp = 8'd0;
    always @(posedge clk) begin
        if (fifo_wrptrclr) wp <= 8'd0;
        else if (fifo_wrinc) begin
            mem[wp[2:0]] <= fifo_datain;
            wp <= wp + 8'd1;
        end
        if (fifo_rdptrclr) rp <= 8'd0;
        else if (fifo_rdinc) begin
            fifo_dataout <= mem[rp[2:0]];
            rp <= rp + 8'd1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0 = clearing after reset, 1 = running, 2 = clearing after flush
    logic [DW-1:0] m_q[$];
    int            m_phase;
    int            m_last;
    bit            m_rdv;
    logic [DW-1:0] m_rdd;
    bit            m_g0, m_g1;
    int            d_g0, d_g1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase = 0;
        m_last  = 1;
        m_rdv   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        p0_valid = 1'b0; p1_valid = 1'b0; pop_req = 1'b0; flush = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_p0_ready", p0_ready, 0);
`ifdef FIFO8X9_CTRL_ALMOST_EN
        chk("rst_almost_full", almost_full, 0);
        chk("rst_almost_empty", almost_empty, 1);
`endif
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic cycle();
        bit run, elig, pr, pop;
        int sz;
        @(negedge clk);
        sz   = m_q.size();
        run  = (m_phase == 1);
        elig = run && (sz < DEPTH) && !flush;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (elig) begin
            if (p0_valid && p1_valid) begin
                if (m_last == 1) m_g0 = 1'b1;
                else             m_g1 = 1'b1;
            end else begin
                m_g0 = p0_valid;
                m_g1 = p1_valid;
            end
        end
        pr  = run && (sz != 0) && !flush;
        pop = pop_req && pr;
        chk("count", count, sz);
        chk("full", full, sz == DEPTH);
        chk("empty", empty, sz == 0);
        chk("p0_ready", p0_ready, m_g0);
        chk("p1_ready", p1_ready, m_g1);
        chk("pop_ready", pop_ready, pr);
        chk("wren", {fifo_wren, fifo_wrinc}, {2{m_g0 | m_g1}});
        chk("rden", {fifo_rden, fifo_rdinc}, {2{pop}});
        chk("ptrclr", {fifo_wrptrclr, fifo_rdptrclr}, {2{!run}});
        chk("datain", fifo_datain, m_g1 ? p1_data : p0_data);
        chk("rd_valid", rd_valid, m_rdv);
        if (m_rdv) chk("rd_data", rd_data, m_rdd);
`ifdef FIFO8X9_CTRL_ALMOST_EN
        chk("almost_full", almost_full, sz >= AF_LVL);
        chk("almost_empty", almost_empty, sz <= AE_LVL);
`endif
        d_g0 += int'(p0_ready);
        d_g1 += int'(p1_ready);
        @(posedge clk);
        m_rdv = pop;
        if (pop) m_rdd = m_q.pop_front();
        case (m_phase)
            0: m_phase = 1;
            2: begin m_q.delete(); m_phase = 1; end
            default: begin
                if (m_g0) begin m_q.push_back(p0_data); m_last = 0; end
                if (m_g1) begin m_q.push_back(p1_data); m_last = 1; end
                if (flush) m_phase = 2;
            end
        endcase
        #1;
    endtask

    initial begin
        int k;
        // reset, then clears for one cycle and idle
        do_reset();
        cycle();
        cycle();

        // fill from producer 0 with 1..9; the ninth is refused
        k = 1;
        p0_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            p0_data = DW'(k);
            cycle();
            if (m_g0) k++;
        end
        chk("fill_pushes", k, 9);
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        p0_valid = 1'b0;
        pop_req  = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        pop_req = 1'b0;
        cycle();
        chk("drain_empty", empty, 1);

        // both producers valid, pops from cycle 3
        d_g0 = 0; d_g1 = 0;
        p0_valid = 1'b1; p1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p0_data = DW'($urandom);
            p1_data = DW'($urandom);
            pop_req = (i >= 2);
            cycle();
        end
        chk("rr_balance", (d_g0 - d_g1 <= 1) && (d_g1 - d_g0 <= 1), 1);
        p1_valid = 1'b0;
        pop_req  = 1'b0;

        // full with push and pop together
        while (m_q.size() < DEPTH) begin
            p0_data = DW'($urandom);
            cycle();
        end
        pop_req = 1'b1;
        cycle();
        pop_req = 1'b0;
        cycle();
        chk("full_pp_count", count, 8);
        p0_valid = 1'b0;

        // empty with push and pop together
        pop_req = 1'b1;
        for (int i = 0; i < 9; i++) cycle();
        p0_valid = 1'b1;
        p0_data  = 9'h155;
        cycle();
        p0_valid = 1'b0;
        cycle();
        pop_req = 1'b0;
        cycle();
        chk("empty_pp_data", rd_data, 9'h155);

        // flush with five stored words, then fresh data
        p0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            p0_data = DW'($urandom);
            cycle();
        end
        p0_valid = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        chk("flush_count", count, 0);
        p0_valid = 1'b1; p0_data = 9'h0AA;
        cycle();
        p0_valid = 1'b0; pop_req = 1'b1;
        cycle();
        pop_req = 1'b0;
        cycle();
        chk("flush_new_data", rd_data, 9'h0AA);

        // reset in the middle of a burst
        p1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p1_data = DW'($urandom);
            cycle();
        end
        do_reset();
        cycle();
        p1_valid = 1'b1; p1_data = 9'h0BB;
        cycle();
        p1_valid = 1'b0; pop_req = 1'b1;
        cycle();
        pop_req = 1'b0;
        cycle();
        chk("reset_new_data", rd_data, 9'h0BB);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            p0_valid = ($urandom_range(0, 3) != 0);
            p1_valid = ($urandom_range(0, 2) != 0);
            p0_data  = DW'($urandom);
            p1_data  = DW'($urandom);
            pop_req  = ($urandom_range(0, 1) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            if (i == 200) do_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
